// File: rtl/debounce_arbiter.sv
// debounce_arbiter: debounces NUM_BTN raw button inputs through one shared
// debounce counter. A round-robin arbiter hands the counter to one unsettled
// button at a time. Each committed change produces a one-cycle press or
// release strobe.
//
// Ports:
//   i_Clk      system clock, rising edge
//   i_Rst      synchronous active-high reset
//   i_Btn      raw asynchronous button levels (1 = pressed)
//   o_Btn      debounced stable levels
//   o_Press    one-cycle strobe on a committed 0->1 change
//   o_Release  one-cycle strobe on a committed 1->0 change
//   o_Busy     shared counter currently granted to a button
module debounce_arbiter #(
  parameter int unsigned NUM_BTN        = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [NUM_BTN-1:0] i_Btn,
  output logic [NUM_BTN-1:0] o_Btn,
  output logic [NUM_BTN-1:0] o_Press,
  output logic [NUM_BTN-1:0] o_Release,
  output logic               o_Busy
);

  localparam int unsigned PTR_W = $clog2(NUM_BTN);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] btn_q, btn_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;

  logic [NUM_BTN-1:0] mismatch;
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   gnt_next;

  // Synchronized level differs from the committed level.
  assign mismatch = sync2_q ^ btn_q;

  // Pointer value after the current grant finishes (wraps modulo NUM_BTN).
  assign gnt_next = (gnt_q == PTR_W'(NUM_BTN - 1)) ? '0 : gnt_q + PTR_W'(1);

  // Round-robin scan: first mismatching button at or above the pointer.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] cand;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      idx  = (32'(ptr_q) + k) % NUM_BTN;
      cand = PTR_W'(idx);
      if (!found && mismatch[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!mismatch[gnt_q]) begin
          // Input bounced back before settling: drop it, move on.
          state_d = IDLE;
          ptr_d   = gnt_next;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMMIT: begin
        btn_d[gnt_q] = ~btn_q[gnt_q];
        if (btn_q[gnt_q]) begin
          release_d[gnt_q] = 1'b1;
        end else begin
          press_d[gnt_q] = 1'b1;
        end
        ptr_d   = gnt_next;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= i_Btn;
      sync2_q   <= sync1_q;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
    end
  end

  assign o_Btn     = btn_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Busy    = busy_q;

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter with NUM_BTN=4, DEBOUNCE_LIMIT=8.
// Edge e counts from the first rising edge that samples the new i_Btn value;
// outputs are sampled 1 time unit after each rising edge.
module tb_debounce_arbiter;

  localparam int unsigned NB  = 4;
  localparam int unsigned LIM = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] o_btn;
  logic [NB-1:0] o_press;
  logic [NB-1:0] o_rel;
  logic          o_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_arbiter #(
    .NUM_BTN       (NB),
    .DEBOUNCE_LIMIT(LIM)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Btn    (btn),
    .o_Btn    (o_btn),
    .o_Press  (o_press),
    .o_Release(o_rel),
    .o_Busy   (o_busy)
  );

  typedef struct {
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] eb;
    logic [NB-1:0] ep;
    logic [NB-1:0] er;
    logic          ebusy;
  } vec_t;

  vec_t vt[29];

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [3:0] eb, input logic [3:0] ep,
                         input logic [3:0] er);
    chk({nm, "_btn"}, o_btn, eb);
    chk({nm, "_press"}, o_press, ep);
    chk({nm, "_release"}, o_rel, er);
  endtask

  initial begin
    // Test 1 (press btn0) and test 4 (release btn0) as a per-edge table.
    vt[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    for (int e = 1; e <= 14; e++) begin
      vt[e] = '{1'b0, 4'b0001, (e >= 12) ? 4'b0001 : 4'b0000,
                (e == 12) ? 4'b0001 : 4'b0000, 4'b0000, (e >= 3 && e <= 11)};
      vt[e + 14] = '{1'b0, 4'b0000, (e >= 12) ? 4'b0000 : 4'b0001,
                     4'b0000, (e == 12) ? 4'b0001 : 4'b0000, (e >= 3 && e <= 11)};
    end

    for (int i = 0; i < 29; i++) begin
      rst = vt[i].rst;
      btn = vt[i].btn;
      tick();
      chk_out($sformatf("t1_row%0d", i), vt[i].eb, vt[i].ep, vt[i].er);
      chk($sformatf("t1_row%0d_busy", i), {3'b000, o_busy}, {3'b000, vt[i].ebusy});
    end

    // Test 2: btn1 bounces for 5 cycles -> abort, nothing committed.
    for (int e = 1; e <= 16; e++) begin
      btn = (e <= 5) ? 4'b0010 : 4'b0000;
      tick();
      chk_out($sformatf("t2_abort_e%0d", e), 4'b0000, 4'b0000, 4'b0000);
      if (e == 5) chk("t2_busy_counting", {3'b000, o_busy}, 4'b0001);
      if (e == 8) chk("t2_busy_aborted", {3'b000, o_busy}, 4'b0000);
    end
    // Pointer now at btn2: btn1 and btn2 together -> btn2 wins first.
    btn = 4'b0110;
    for (int e = 1; e <= 22; e++) begin
      tick();
      chk_out($sformatf("t2_rr_e%0d", e),
              (e >= 22) ? 4'b0110 : (e >= 12) ? 4'b0100 : 4'b0000,
              (e == 22) ? 4'b0010 : (e == 12) ? 4'b0100 : 4'b0000, 4'b0000);
    end

    // Test 3: reset (pointer=0), btn0 and btn2 rise together.
    rst = 1'b1;
    btn = 4'b0000;
    tick();
    chk_out("t3_reset", 4'b0000, 4'b0000, 4'b0000);
    chk("t3_reset_busy", {3'b000, o_busy}, 4'b0000);
    rst = 1'b0;
    btn = 4'b0101;
    for (int e = 1; e <= 24; e++) begin
      tick();
      chk_out($sformatf("t3_e%0d", e),
              (e >= 22) ? 4'b0101 : (e >= 12) ? 4'b0001 : 4'b0000,
              (e == 22) ? 4'b0100 : (e == 12) ? 4'b0001 : 4'b0000, 4'b0000);
    end

    // Test 6: pointer=3; btn3 press and btn0 release pending -> btn3 first.
    btn = 4'b1100;
    for (int e = 1; e <= 24; e++) begin
      tick();
      chk_out($sformatf("t6_e%0d", e),
              (e >= 22) ? 4'b1100 : (e >= 12) ? 4'b1101 : 4'b0101,
              (e == 12) ? 4'b1000 : 4'b0000,
              (e == 22) ? 4'b0001 : 4'b0000);
    end

    // Test 5: reset during COUNT discards the debounce, then it restarts.
    rst = 1'b1;
    btn = 4'b0000;
    tick();
    chk_out("t5_pre_reset", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    btn = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk_out($sformatf("t5_count_e%0d", e), 4'b0000, 4'b0000, 4'b0000);
    end
    chk("t5_busy_before_reset", {3'b000, o_busy}, 4'b0001);
    rst = 1'b1;
    tick();
    chk_out("t5_mid_reset", 4'b0000, 4'b0000, 4'b0000);
    chk("t5_mid_reset_busy", {3'b000, o_busy}, 4'b0000);
    rst = 1'b0;
    for (int e = 8; e <= 21; e++) begin
      tick();
      chk_out($sformatf("t5_restart_e%0d", e), (e >= 19) ? 4'b0001 : 4'b0000,
              (e == 19) ? 4'b0001 : 4'b0000, 4'b0000);
      if (e == 9) chk("t5_busy_e9", {3'b000, o_busy}, 4'b0000);
      if (e == 10) chk("t5_busy_e10", {3'b000, o_busy}, 4'b0001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
